// File: rtl/regblock_port_arbiter_pkg.sv
// Shared constants and helpers for the per-wavefront register block arbiter.
// Imported by the interface, the round-robin arbiter and the top level.
package regblock_arb_pkg;

  localparam int ADDR_W           = 6;
  localparam int NUM_ENTRIES      = 40;
  localparam int DEFAULT_BITWIDTH = 11;
  localparam int NUM_RD           = 2;

  typedef logic [ADDR_W-1:0] addr_t;

  function automatic logic addr_in_range(input addr_t addr);
    return (addr < ADDR_W'(NUM_ENTRIES));
  endfunction

endpackage

// File: rtl/regblock_port_arbiter_if.sv
// Requester-side bus of the register block arbiter: write and read request ports.
// master = requesters, slave = arbiter.
interface regblock_port_arbiter_if #(
  parameter int BITWIDTH = 11,
  parameter int NUM_WR   = 3
);
  import regblock_arb_pkg::*;

  logic [NUM_WR-1:0]          wr_req;
  logic [ADDR_W*NUM_WR-1:0]   wr_addr;
  logic [BITWIDTH*NUM_WR-1:0] wr_data;
  logic [NUM_WR-1:0]          wr_gnt;

  logic [NUM_RD-1:0]          rd_req;
  logic [ADDR_W*NUM_RD-1:0]   rd_addr;
  logic [NUM_RD-1:0]          rd_gnt;
  logic                       rd_valid;
  logic                       rd_id;
  logic [BITWIDTH-1:0]        rd_data;

  modport master (
    output wr_req, wr_addr, wr_data, rd_req, rd_addr,
    input  wr_gnt, rd_gnt, rd_valid, rd_id, rd_data
  );

  modport slave (
    input  wr_req, wr_addr, wr_data, rd_req, rd_addr,
    output wr_gnt, rd_gnt, rd_valid, rd_id, rd_data
  );

endinterface

// File: rtl/regblock_port_arbiter_rr_arbiter.sv
// N-way round-robin arbiter with a registered priority pointer; the grant is
// combinational, and after a grant to i the pointer moves to (i+1) mod N.
module rr_arbiter
  import regblock_arb_pkg::*;
#(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] ptr_r;
  logic [PTR_W-1:0] win_idx_s;
  logic [PTR_W-1:0] idx_v_s;
  logic             found_s;
  logic             hit_s;
  int               idx_s;

  // search from the pointer upward, wrapping, for the first active request
  always_comb begin
    gnt       = '0;
    found_s   = 1'b0;
    win_idx_s = '0;
    idx_s     = 0;
    idx_v_s   = '0;
    hit_s     = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx_s     = int'(ptr_r) + k;
      idx_s     = (idx_s >= N) ? (idx_s - N) : idx_s;
      idx_v_s   = PTR_W'(idx_s);
      hit_s     = req[idx_v_s] & ~found_s & ~rst;
      gnt[idx_v_s] = gnt[idx_v_s] | hit_s;
      win_idx_s = hit_s ? idx_v_s : win_idx_s;
      found_s   = found_s | hit_s;
    end
  end

  // priority pointer register
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r <= '0;
    end else if (advance && found_s) begin
      ptr_r <= (win_idx_s == PTR_W'(N - 1)) ? '0 : (win_idx_s + PTR_W'(1));
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/regblock_port_arbiter.sv
// Shares one read and one write port of the register block between NUM_WR
// writers and two readers. Optional forwarding: `define REGBLOCK_ARB_BYPASS_EN.
module regblock_port_arbiter
  import regblock_arb_pkg::*;
#(
  parameter int BITWIDTH = DEFAULT_BITWIDTH,
  parameter int NUM_WR   = 3
) (
  input  logic                clk,
  input  logic                rst,
  regblock_port_arbiter_if.slave bus,
  output logic                rb_write,
  output logic [ADDR_W-1:0]   rb_writeregsel,
  output logic [BITWIDTH-1:0] rb_writedata,
  output logic [ADDR_W-1:0]   rb_readregsel,
  input  logic [BITWIDTH-1:0] rb_readdata
);

  logic [NUM_WR-1:0]   wr_gnt_s;
  logic                wr_any_s;
  logic [ADDR_W-1:0]   wr_addr_s;
  logic [BITWIDTH-1:0] wr_data_s;

  logic [NUM_RD-1:0]   hazard_s;
  logic [NUM_RD-1:0]   rd_arb_req_s;
  logic [NUM_RD-1:0]   rd_gnt_s;
  logic                rd_any_s;
  logic                rd_win_s;
  logic [ADDR_W-1:0]   rd_addr_s;
  logic [BITWIDTH-1:0] rd_value_s;

  logic                rd_valid_r;
  logic                rd_id_r;
  logic [BITWIDTH-1:0] rd_data_r;

  rr_arbiter #(.N(NUM_WR)) u_wr_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (bus.wr_req),
    .advance (1'b1),
    .gnt     (wr_gnt_s)
  );

  assign bus.wr_gnt = wr_gnt_s;

  // one-hot grant selects the winning writer's operands
  always_comb begin
    wr_any_s  = |wr_gnt_s;
    wr_addr_s = '0;
    wr_data_s = '0;
    for (int i = 0; i < NUM_WR; i++) begin
      wr_addr_s = wr_addr_s | ({ADDR_W{wr_gnt_s[i]}} & bus.wr_addr[ADDR_W*i +: ADDR_W]);
      wr_data_s = wr_data_s | ({BITWIDTH{wr_gnt_s[i]}} & bus.wr_data[BITWIDTH*i +: BITWIDTH]);
    end
  end

  // write pipeline: out-of-range writes are granted but never enabled
  always_ff @(posedge clk) begin
    if (rst) begin
      rb_write       <= 1'b0;
      rb_writeregsel <= '0;
      rb_writedata   <= '0;
    end else if (wr_any_s) begin
      rb_write       <= addr_in_range(wr_addr_s);
      rb_writeregsel <= wr_addr_s;
      rb_writedata   <= wr_data_s;
    end else begin
      rb_write       <= 1'b0;
    end
  end

  // a read of the entry whose write is pending this cycle would see stale data
  always_comb begin
    hazard_s = '0;
    for (int j = 0; j < NUM_RD; j++) begin
      hazard_s[j] = rb_write & (bus.rd_addr[ADDR_W*j +: ADDR_W] == rb_writeregsel);
    end
  end

`ifdef REGBLOCK_ARB_BYPASS_EN
  assign rd_arb_req_s = bus.rd_req;
`else
  assign rd_arb_req_s = bus.rd_req & ~hazard_s;
`endif

  rr_arbiter #(.N(NUM_RD)) u_rd_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (rd_arb_req_s),
    .advance (1'b1),
    .gnt     (rd_gnt_s)
  );

  assign bus.rd_gnt = rd_gnt_s;
  assign rd_any_s   = |rd_gnt_s;
  assign rd_win_s   = rd_gnt_s[1];
  assign rd_addr_s  = rd_win_s ? bus.rd_addr[2*ADDR_W-1:ADDR_W] : bus.rd_addr[ADDR_W-1:0];
  assign rb_readregsel = rd_any_s ? rd_addr_s : '0;

  // read result source: zero, forwarded pending write, or block data
  always_comb begin
    rd_value_s = '0;
    if (!addr_in_range(rd_addr_s)) begin
      rd_value_s = '0;
`ifdef REGBLOCK_ARB_BYPASS_EN
    end else if (hazard_s[rd_win_s]) begin
      rd_value_s = rb_writedata;
`endif
    end else begin
      rd_value_s = rb_readdata;
    end
  end

  // read capture register
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_r <= 1'b0;
      rd_id_r    <= 1'b0;
      rd_data_r  <= '0;
    end else if (rd_any_s) begin
      rd_valid_r <= 1'b1;
      rd_id_r    <= rd_win_s;
      rd_data_r  <= rd_value_s;
    end else begin
      rd_valid_r <= 1'b0;
    end
  end

  assign bus.rd_valid = rd_valid_r;
  assign bus.rd_id    = rd_id_r;
  assign bus.rd_data  = rd_data_r;

endmodule

// File: tb/tb_regblock_port_arbiter.sv
// Table-driven bench for regblock_port_arbiter with a register-block model and
// a scoreboard of next-cycle expectations.
module tb_regblock_port_arbiter;
  import regblock_arb_pkg::*;

  localparam int BW = 11;
  localparam int NW = 3;

  typedef struct {
    logic        rst;
    logic [2:0]  wr_req;
    logic [17:0] wa;
    logic [32:0] wd;
    logic [1:0]  rd_req;
    logic [11:0] ra;
    logic [2:0]  e_wgnt;
    logic [1:0]  e_rgnt;
    logic [10:0] e_rdata;
  } vec_t;

  typedef struct {
    logic        full;
    logic        rb_write;
    logic        chk_w;
    logic [5:0]  sel;
    logic [10:0] wdata;
    logic        rd_valid;
    logic        rd_id;
    logic [10:0] rd_data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic mem_clear;
  logic          rb_write;
  logic [5:0]    rb_writeregsel;
  logic [BW-1:0] rb_writedata;
  logic [5:0]    rb_readregsel;
  logic [BW-1:0] rb_readdata;
  logic [BW-1:0] mem [64];

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];
  exp_t sb[$];

  always #5 clk = ~clk;

  regblock_port_arbiter_if #(.BITWIDTH(BW), .NUM_WR(NW)) bus ();

  regblock_port_arbiter #(.BITWIDTH(BW), .NUM_WR(NW)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .rb_write       (rb_write),
    .rb_writeregsel (rb_writeregsel),
    .rb_writedata   (rb_writedata),
    .rb_readregsel  (rb_readregsel),
    .rb_readdata    (rb_readdata)
  );

  // register block model; entries beyond the valid range hold a nonzero pattern
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 64; i++) mem[i] <= (i >= NUM_ENTRIES) ? 11'h3C3 : 11'h000;
    end else if (rb_write) begin
      mem[rb_writeregsel] <= rb_writedata;
    end
  end
  assign rb_readdata = mem[rb_readregsel];

  function automatic vec_t mk(input logic r, input logic [2:0] wreq, input int wsel,
                              input logic [5:0] waddr, input logic [10:0] wdata,
                              input logic [1:0] rreq, input logic [5:0] ra0, input logic [5:0] ra1,
                              input logic [2:0] egw, input logic [1:0] egr, input logic [10:0] erd);
    vec_t v;
    v.rst    = r;
    v.wr_req = wreq;
    v.wa     = {6'd12, 6'd11, 6'd10};
    v.wd     = {11'h122, 11'h111, 11'h100};
    if (wsel >= 0) begin
      v.wa[6*wsel +: 6]   = waddr;
      v.wd[11*wsel +: 11] = wdata;
    end
    v.rd_req  = rreq;
    v.ra      = {ra1, ra0};
    v.e_wgnt  = egw;
    v.e_rgnt  = egr;
    v.e_rdata = erd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_regs();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      chk("rb_write", 32'(rb_write), 32'(e.rb_write));
      chk("rd_valid", 32'(bus.rd_valid), 32'(e.rd_valid));
      if (e.full || e.chk_w) begin
        chk("rb_writeregsel", 32'(rb_writeregsel), 32'(e.sel));
        chk("rb_writedata", 32'(rb_writedata), 32'(e.wdata));
      end
      if (e.full || e.rd_valid) begin
        chk("rd_id", 32'(bus.rd_id), 32'(e.rd_id));
        chk("rd_data", 32'(bus.rd_data), 32'(e.rd_data));
      end
    end
  endtask

  task automatic push_exp(input vec_t v);
    exp_t e;
    int   wi;
    e = '{full: 1'b0, rb_write: 1'b0, chk_w: 1'b0, sel: 6'd0, wdata: 11'h000,
          rd_valid: 1'b0, rd_id: 1'b0, rd_data: 11'h000};
    if (v.rst) begin
      e.full = 1'b1;
    end else begin
      wi = v.e_wgnt[1] ? 1 : (v.e_wgnt[2] ? 2 : 0);
      if (v.e_wgnt != 3'b000) begin
        e.rb_write = (v.wa[6*wi +: 6] < 6'd40);
        e.chk_w    = e.rb_write;
        e.sel      = v.wa[6*wi +: 6];
        e.wdata    = v.wd[11*wi +: 11];
      end
      if (v.e_rgnt != 2'b00) begin
        e.rd_valid = 1'b1;
        e.rd_id    = v.e_rgnt[1];
        e.rd_data  = v.e_rdata;
      end
    end
    sb.push_back(e);
  endtask

  initial begin
    // reset, write fairness, mid-traffic reset
    vecs.push_back(mk(1'b1, 3'b000, -1, 6'd0, 11'h0, 2'b00, 6'd0, 6'd0, 3'b000, 2'b00, 11'h0));
    for (int k = 0; k < 6; k++)
      vecs.push_back(mk(1'b0, 3'b111, -1, 6'd0, 11'h0, 2'b00, 6'd0, 6'd0, 3'(1 << (k % 3)), 2'b00, 11'h0));
    vecs.push_back(mk(1'b0, 3'b111, -1, 6'd0, 11'h0, 2'b00, 6'd0, 6'd0, 3'b001, 2'b00, 11'h0));
    vecs.push_back(mk(1'b1, 3'b111, -1, 6'd0, 11'h0, 2'b11, 6'd10, 6'd11, 3'b000, 2'b00, 11'h0));
    // read contention 0,1,0,1 (requester 0 hazarded in the second cycle)
    vecs.push_back(mk(1'b0, 3'b111, -1, 6'd0, 11'h0, 2'b11, 6'd10, 6'd11, 3'b001, 2'b01, 11'h100));
    vecs.push_back(mk(1'b0, 3'b000, -1, 6'd0, 11'h0, 2'b11, 6'd10, 6'd11, 3'b000, 2'b10, 11'h111));
    vecs.push_back(mk(1'b0, 3'b000, -1, 6'd0, 11'h0, 2'b11, 6'd10, 6'd11, 3'b000, 2'b01, 11'h100));
    vecs.push_back(mk(1'b0, 3'b000, -1, 6'd0, 11'h0, 2'b11, 6'd10, 6'd11, 3'b000, 2'b10, 11'h111));
    // hazard on requester 0 while it holds priority
    vecs.push_back(mk(1'b0, 3'b001, 0, 6'd20, 11'h2AA, 2'b00, 6'd0, 6'd0, 3'b001, 2'b00, 11'h0));
`ifdef REGBLOCK_ARB_BYPASS_EN
    vecs.push_back(mk(1'b0, 3'b000, -1, 6'd0, 11'h0, 2'b11, 6'd20, 6'd11, 3'b000, 2'b01, 11'h2AA));
`else
    vecs.push_back(mk(1'b0, 3'b000, -1, 6'd0, 11'h0, 2'b11, 6'd20, 6'd11, 3'b000, 2'b10, 11'h111));
`endif
    vecs.push_back(mk(1'b0, 3'b000, -1, 6'd0, 11'h0, 2'b01, 6'd20, 6'd0, 3'b000, 2'b01, 11'h2AA));
    // round trip through entry 7
    vecs.push_back(mk(1'b0, 3'b010, 1, 6'd7, 11'h5A5, 2'b00, 6'd0, 6'd0, 3'b010, 2'b00, 11'h0));
    vecs.push_back(mk(1'b0, 3'b000, -1, 6'd0, 11'h0, 2'b00, 6'd0, 6'd0, 3'b000, 2'b00, 11'h0));
    vecs.push_back(mk(1'b0, 3'b000, -1, 6'd0, 11'h0, 2'b10, 6'd0, 6'd7, 3'b000, 2'b10, 11'h5A5));
    // read-after-pending-write on entry 3
    vecs.push_back(mk(1'b0, 3'b100, 2, 6'd3, 11'h123, 2'b00, 6'd0, 6'd0, 3'b100, 2'b00, 11'h0));
`ifdef REGBLOCK_ARB_BYPASS_EN
    vecs.push_back(mk(1'b0, 3'b000, -1, 6'd0, 11'h0, 2'b01, 6'd3, 6'd0, 3'b000, 2'b01, 11'h123));
    vecs.push_back(mk(1'b0, 3'b000, -1, 6'd0, 11'h0, 2'b00, 6'd0, 6'd0, 3'b000, 2'b00, 11'h0));
`else
    vecs.push_back(mk(1'b0, 3'b000, -1, 6'd0, 11'h0, 2'b01, 6'd3, 6'd0, 3'b000, 2'b00, 11'h0));
    vecs.push_back(mk(1'b0, 3'b000, -1, 6'd0, 11'h0, 2'b01, 6'd3, 6'd0, 3'b000, 2'b01, 11'h123));
`endif
    // same-cycle read and write of entry 3 returns the old value
    vecs.push_back(mk(1'b0, 3'b001, 0, 6'd3, 11'h456, 2'b10, 6'd0, 6'd3, 3'b001, 2'b10, 11'h123));
    vecs.push_back(mk(1'b0, 3'b000, -1, 6'd0, 11'h0, 2'b00, 6'd0, 6'd0, 3'b000, 2'b00, 11'h0));
    // out-of-range write and reads
    vecs.push_back(mk(1'b0, 3'b010, 1, 6'd45, 11'h7FF, 2'b01, 6'd45, 6'd0, 3'b010, 2'b01, 11'h0));
    vecs.push_back(mk(1'b0, 3'b000, -1, 6'd0, 11'h0, 2'b10, 6'd0, 6'd45, 3'b000, 2'b10, 11'h0));
    vecs.push_back(mk(1'b0, 3'b000, -1, 6'd0, 11'h0, 2'b01, 6'd3, 6'd0, 3'b000, 2'b01, 11'h456));

    rst         = 1'b1;
    mem_clear   = 1'b1;
    bus.wr_req  = '0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.rd_req  = '0;
    bus.rd_addr = '0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      if (i > 0) check_regs();
      mem_clear   = (i == 0);
      rst         = vecs[i].rst;
      bus.wr_req  = vecs[i].wr_req;
      bus.wr_addr = vecs[i].wa;
      bus.wr_data = vecs[i].wd;
      bus.rd_req  = vecs[i].rd_req;
      bus.rd_addr = vecs[i].ra;
      #1;
      chk($sformatf("wr_gnt[v%0d]", i), 32'(bus.wr_gnt), 32'(vecs[i].e_wgnt));
      chk($sformatf("rd_gnt[v%0d]", i), 32'(bus.rd_gnt), 32'(vecs[i].e_rgnt));
      push_exp(vecs[i]);
    end
    @(negedge clk);
    check_regs();
    bus.wr_req = '0;
    bus.rd_req = '0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
